// File: rtl/pkt_wrr_sched_avlstrm.sv
// Packet-granular weighted round-robin scheduler for N Avalon-ST sources
// sharing one egress. Credits are counted in packets per round; a granted
// source owns the egress until its eop beat is accepted.
module pkt_wrr_sched_avlstrm #(
  parameter int N        = 5,
  parameter int WIDTH    = 512,
  parameter int EMPTY_W  = 6,
  parameter int WEIGHT_W = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [N*WIDTH-1:0]      in_data,
  input  logic [N*EMPTY_W-1:0]    in_empty,
  input  logic [N-1:0]            in_valid,
  input  logic [N-1:0]            in_sop,
  input  logic [N-1:0]            in_eop,
  output logic [N-1:0]            in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [EMPTY_W-1:0]      out_empty,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_eop,
  input  logic                    out_ready,
  input  logic [N*WEIGHT_W-1:0]   weight,
  output logic [N-1:0]            cur_grant,
  output logic                    busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]          state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [WEIGHT_W-1:0] credit   [N];
  logic [WEIGHT_W-1:0] credit_d [N];

  logic [N-1:0]        elig;
  logic [N-1:0]        cred_elig;
  logic [N-1:0]        cand;
  logic                any_cred;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                eop_hs;
  logic                do_pick;

  // Eligibility: a packet head is waiting and the source is enabled.
  always_comb begin
    elig      = '0;
    cred_elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i]      = in_valid[i] & in_sop[i] & (weight[i*WEIGHT_W +: WEIGHT_W] != '0);
      cred_elig[i] = elig[i] & (credit[i] != '0);
    end
    any_cred = |cred_elig;
    // Without any credited candidate the round is over: credits reload and
    // every eligible source competes again.
    cand     = any_cred ? cred_elig : elig;
  end

  // Rotating priority search starting just after the last granted source.
  always_comb begin
    int p;
    pick_found = 1'b0;
    pick_idx   = '0;
    p          = int'(rr_ptr);
    for (int k = 0; k < N; k++) begin
      p = (p >= N - 1) ? 0 : p + 1;
      if (!pick_found && cand[p]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(p);
      end
    end
  end

  assign do_pick = (state == IDLE) & pick_found;

  // Next credits: optional reload for the whole round, then charge the winner.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      credit_d[i] = credit[i];
      if (do_pick) begin
        credit_d[i] = any_cred ? credit[i] : weight[i*WEIGHT_W +: WEIGHT_W];
        if (pick_idx == IDX_W'(i))
          credit_d[i] = credit_d[i] - 1'b1;
      end
    end
  end

  // Zero-latency passthrough of the granted source while BUSY.
  always_comb begin
    out_data  = '0;
    out_empty = '0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if ((state == BUSY) && cur_grant[i]) begin
        out_data    = in_data[i*WIDTH +: WIDTH];
        out_empty   = in_empty[i*EMPTY_W +: EMPTY_W];
        out_valid   = in_valid[i];
        out_sop     = in_sop[i];
        out_eop     = in_eop[i];
        in_ready[i] = out_ready;
      end
    end
    eop_hs = out_valid & out_eop & out_ready;
  end

  assign busy = (state == BUSY);

  // Grant state machine: pick in IDLE, release on the accepted eop beat.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cur_grant <= '0;
      rr_ptr    <= IDX_W'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= BUSY;
            cur_grant <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            rr_ptr    <= pick_idx;
          end
        end
        default: begin
          if (eop_hs) begin
            state     <= IDLE;
            cur_grant <= '0;
          end
        end
      endcase
    end
  end

  // Per-source packet credits.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < N; i++)
        credit[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        credit[i] <= credit_d[i];
    end
  end

endmodule

// File: tb/tb_pkt_wrr_sched_avlstrm.sv
// Directed scoreboard bench for pkt_wrr_sched_avlstrm.
module tb_pkt_wrr_sched_avlstrm;
  localparam int N        = 5;
  localparam int WIDTH    = 512;
  localparam int EMPTY_W  = 6;
  localparam int WEIGHT_W = 4;

  logic                  Clk = 1'b0;
  logic                  Rst;
  logic [N*WIDTH-1:0]    in_data;
  logic [N*EMPTY_W-1:0]  in_empty;
  logic [N-1:0]          in_valid, in_sop, in_eop, in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [EMPTY_W-1:0]    out_empty;
  logic                  out_valid, out_sop, out_eop, out_ready;
  logic [N*WEIGHT_W-1:0] weight;
  logic [N-1:0]          cur_grant;
  logic                  busy;

  always #5 Clk = ~Clk;

  pkt_wrr_sched_avlstrm #(.N(N), .WIDTH(WIDTH), .EMPTY_W(EMPTY_W), .WEIGHT_W(WEIGHT_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_data(in_data), .in_empty(in_empty), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready),
    .weight(weight), .cur_grant(cur_grant), .busy(busy)
  );

  typedef struct packed {
    logic [31:0]        word;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   pkts_left[N];
  int   len[N];
  int   beat[N];
  int   seq[N];
  int   exp_seq[N];
  logic [N-1:0] hs_q = '0;
  logic toggle_rdy = 1'b0;
  logic rec_times = 1'b0;
  int   cyc = 0;
  int   base_cyc = 0;
  int   beat_times[$];

  function automatic logic [31:0] mk_word(int s, int q, int b);
    return {8'(s), 8'(q), 8'(b), 8'hA5};
  endfunction

  function automatic logic [EMPTY_W-1:0] mk_empty(int s, int b, int l);
    return (b == l - 1) ? EMPTY_W'(s * 3 + 1) : '0;
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_beat(int s, int q, int b, int l);
    exp_t x;
    x.word  = mk_word(s, q, b);
    x.sop   = (b == 0);
    x.eop   = (b == l - 1);
    x.empty = mk_empty(s, b, l);
    sb.push_back(x);
  endfunction

  function automatic void push_pkt(int s, int l);
    for (int b = 0; b < l; b++) push_beat(s, exp_seq[s], b, l);
    exp_seq[s]++;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (pkts_left[i] > 0);
      in_sop[i]   = (beat[i] == 0);
      in_eop[i]   = (beat[i] == len[i] - 1);
      in_data[i*WIDTH +: WIDTH]       = {(WIDTH/32){mk_word(i, seq[i], beat[i])}};
      in_empty[i*EMPTY_W +: EMPTY_W]  = mk_empty(i, beat[i], len[i]);
    end
  endtask

  always @(posedge Clk) cyc = cyc + 1;

  // Source models advance one beat after each accepted handshake.
  always @(posedge Clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (Rst) beat[i] = 0;
      else if (hs_q[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          seq[i]++;
          pkts_left[i]--;
        end else beat[i]++;
      end
    end
    if (toggle_rdy) out_ready = ~out_ready;
    drive_srcs();
  end

  // Egress monitor and scoreboard check.
  always @(negedge Clk) begin
    hs_q = in_valid & in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_beat", 512'(out_valid), 512'(0));
      else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, {(WIDTH/32){mon_e.word}});
        chk("out_sop", 512'(out_sop), 512'(mon_e.sop));
        chk("out_eop", 512'(out_eop), 512'(mon_e.eop));
        chk("out_empty", 512'(out_empty), 512'(mon_e.empty));
      end
      n_pop++;
      if (rec_times) beat_times.push_back(cyc - base_cyc + 1);
    end
  end

  task automatic enter_reset();
    @(posedge Clk); #2;
    Rst = 1'b1;
    toggle_rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin pkts_left[i] = 0; len[i] = 1; end
    drive_srcs();
    repeat (2) @(posedge Clk);
  endtask

  task automatic leave_reset();
    @(posedge Clk); #2;
    Rst = 1'b0;
    base_cyc = cyc;
  endtask

  task automatic wait_drain(string tag, int maxc);
    int c = 0;
    while (sb.size() != 0 && c < maxc) begin @(posedge Clk); c++; end
    chk({tag, "_drain_left"}, 512'(sb.size()), 512'(0));
    repeat (3) @(posedge Clk);
  endtask

  initial begin
    int c;
    Rst = 1'b1;
    out_ready = 1'b1;
    weight = {N{4'd1}};
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 0; len[i] = 1; beat[i] = 0; seq[i] = 0; exp_seq[i] = 0;
    end
    drive_srcs();

    // Round-robin order and bubble timing, all weights 1
    enter_reset();
    for (int i = 0; i < N; i++) pkts_left[i] = 1;
    drive_srcs();
    #1;
    chk("rst_cur_grant", 512'(cur_grant), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    for (int i = 0; i < N; i++) push_pkt(i, 1);
    beat_times.delete();
    rec_times = 1'b1;
    leave_reset();
    wait_drain("t1", 100);
    rec_times = 1'b0;
    chk("t1_nbeats", 512'(beat_times.size()), 512'(5));
    for (int k = 0; k < beat_times.size(); k++)
      chk("t1_beat_cycle", 512'(beat_times[k]), 512'(2 + 2 * k));

    // Weighted shares: src4 weight 3
    enter_reset();
    weight = {4'd3, 4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 4; i++) pkts_left[i] = 10;
    pkts_left[4] = 30;
    drive_srcs();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) push_pkt(i, 1);
      for (int k = 0; k < 3; k++) push_pkt(4, 1);
    end
    leave_reset();
    wait_drain("t2", 400);

    // Disabled source never granted
    enter_reset();
    weight = {4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
    pkts_left[2] = 1;
    drive_srcs();
    leave_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      chk("t3_in_ready", 512'(in_ready), 512'(0));
      chk("t3_cur_grant", 512'(cur_grant), 512'(0));
      chk("t3_busy", 512'(busy), 512'(0));
    end
    pkts_left[2] = 0;
    drive_srcs();

    // Multi-beat packet under backpressure, competing source arrives mid-packet
    enter_reset();
    weight = {N{4'd1}};
    len[1] = 4;
    pkts_left[1] = 1;
    drive_srcs();
    push_pkt(1, 4);
    push_pkt(0, 1);
    toggle_rdy = 1'b1;
    leave_reset();
    c = 0;
    while (beat[1] != 1 && c < 50) begin @(posedge Clk); #2; c++; end
    chk("t4_beat2_reached", 512'(beat[1]), 512'(1));
    pkts_left[0] = 1;
    drive_srcs();
    c = 0;
    while (sb.size() > 1 && c < 100) begin
      @(negedge Clk);
      chk("t4_in_ready0", 512'(in_ready[0]), 512'(0));
      c++;
    end
    wait_drain("t4", 100);
    toggle_rdy = 1'b0;
    out_ready = 1'b1;

    // Weight change while a credit is still outstanding
    enter_reset();
    weight = {4'd1, 4'd2, 4'd1, 4'd1, 4'd1};
    pkts_left[0] = 3;
    pkts_left[3] = 4;
    drive_srcs();
    push_pkt(0, 1); push_pkt(3, 1); push_pkt(3, 1);
    push_pkt(0, 1); push_pkt(3, 1);
    push_pkt(0, 1); push_pkt(3, 1);
    n_pop = 0;
    leave_reset();
    c = 0;
    while (n_pop < 2 && c < 50) begin @(posedge Clk); #2; c++; end
    chk("t5_two_popped", 512'(n_pop), 512'(2));
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    wait_drain("t5", 100);

    // Reset in the middle of a 6-beat packet
    enter_reset();
    weight = {N{4'd1}};
    len[2] = 6;
    pkts_left[2] = 1;
    drive_srcs();
    push_beat(2, exp_seq[2], 0, 6);
    push_beat(2, exp_seq[2], 1, 6);
    leave_reset();
    c = 0;
    while (beat[2] != 2 && c < 50) begin @(posedge Clk); #2; c++; end
    chk("t6_beat3_reached", 512'(beat[2]), 512'(2));
    Rst = 1'b1;
    len[0] = 1;
    pkts_left[0] = 1;
    drive_srcs();
    #1;
    chk("t6_cur_grant", 512'(cur_grant), 512'(0));
    chk("t6_busy", 512'(busy), 512'(0));
    chk("t6_in_ready", 512'(in_ready), 512'(0));
    chk("t6_out_valid", 512'(out_valid), 512'(0));
    chk("t6_partial_seen", 512'(sb.size()), 512'(0));
    push_pkt(0, 1);
    push_pkt(2, 6);
    repeat (2) @(posedge Clk);
    leave_reset();
    wait_drain("t6", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_wrr_sched_avlstrm.md
Name: pkt_wrr_sched_avlstrm

Overview:
- Weighted round-robin, packet-granular scheduler sharing one 512-bit Avalon-ST egress (toward eth_out) between N packet sources, e.g. the five out0..out4 result streams.
- Replaces the cascaded fixed 3:1 packet muxes with one arbiter. Per-source packet-credit weights give configurable bandwidth shares.
- Once a source is granted, it keeps the egress until its eop beat is accepted, so packets are never interleaved.

Parameters:
- N, 5, number of source streams
- WIDTH, 512, data width in bits
- EMPTY_W, 6, empty field width
- WEIGHT_W, 4, per-source weight / credit width

Ports:
- Clk  in  1  clock
- Rst  in  1  reset: asynchronous, active-high
- in_data  in  N*WIDTH  source data; source i occupies [i*WIDTH +: WIDTH]
- in_empty  in  N*EMPTY_W  source empty fields
- in_valid  in  N  per-source valid
- in_sop  in  N  per-source start of packet
- in_eop  in  N  per-source end of packet
- in_ready  out  N  per-source ready
- out_data  out  WIDTH  egress data
- out_empty  out  EMPTY_W  egress empty
- out_valid  out  1  egress valid
- out_sop  out  1  egress start of packet
- out_eop  out  1  egress end of packet
- out_ready  in  1  egress ready
- weight  in  N*WEIGHT_W  packets per round for each source; weight 0 disables the source
- cur_grant  out  N  one-hot registered grant; 0 when IDLE
- busy  out  1  high in state BUSY

Behaviour:
- Handshake: a beat transfers on valid & ready. Sources hold valid, data and flags stable until ready.
- Reset values: state=IDLE; cur_grant=0; busy=0; rr_ptr=N-1; all credits=0; in_ready=0; out_valid=0.
- Eligibility: source i is eligible when in_valid[i] & in_sop[i] & (weight[i]!=0).
- Credit-ready eligibility: source i is credit-eligible when it is eligible and credit[i]!=0.
- IDLE state:
  - If no source is eligible, remain in IDLE.
  - If at least one source is credit-eligible, pick the first one searching upward from rr_ptr+1, wrapping modulo N.
  - Otherwise (some sources eligible, none with credit), reload every credit[i]=weight[i] that cycle and pick from eligible sources with the same search order.
  - On a pick of source g at the clock edge: cur_grant=onehot(g); rr_ptr=g; credit[g]=(loaded or current value)-1; state goes to BUSY.
  - All in_ready=0 and out_valid=0 in IDLE, so there is exactly one bubble cycle per packet.
- BUSY state (grant g):
  - Combinational passthrough, zero latency: out_*=in_*[g] and in_ready[g]=out_ready. Every other in_ready is 0.
  - On a beat with in_eop[g] & in_valid[g] & out_ready: cur_grant=0, state goes to IDLE at the next edge.
  - Beats of non-granted sources are ignored.
  - An in_sop mid-packet is passed through unchanged; no checking is done.
- Weight changes: they take effect only at the next reload. Credits in flight are not truncated.
- Simultaneous events: a reload and a pick happen in the same cycle. A decrement happens only on the picked source.
- Credit underflow is impossible, because credit is only ever decremented when it is nonzero.
- Single-beat packets (sop & eop together): occupy one BUSY cycle, then return to IDLE.
- Reset asserted mid-packet: immediately clears state, grant and credits. The partial packet is truncated at the egress; downstream must tolerate this.
- Throughput: an M-beat packet occupies M+1 cycles when out_ready is held high.

Test Plan:
- Reset, weights all 1, sources 0..4 each offering one 1-beat packet, out_ready=1 -> egress order 0,1,2,3,4; a new packet every 2 cycles; first out_valid on cycle 2 after reset release.
- weight={1,1,1,1,3} (src4=3), all sources continuously offering 1-beat packets -> each round contains src4 three times and sources 0..3 once each (7 packets per round); repeats over 70 packets.
- weight[2]=0, only src2 valid -> stays IDLE, in_ready=0 forever, cur_grant=0.
- Src1 sends a 4-beat packet, src0 becomes valid on beat 2, out_ready toggled 1,0,1,… -> all 4 src1 beats are contiguous on the egress; src0 is granted only after the src1 eop handshake; in_ready[0]=0 throughout.
- weight changed from 2 to 1 for src3 while credit[3]=1 remains -> src3 gets 1 more packet in the current round, then 1 per round after the reload.
- Assert Rst on beat 3 of a 6-beat packet -> cur_grant=0, busy=0, in_ready=0 the same cycle; after release, arbitration restarts from src0.
